// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl_if
//  Description : Bundles the signals of ram_fifo_ctrl. It carries the producer
//                push handshake, the consumer pop handshake and the dual-port
//                RAM read/write bus.
//                  slave  : controller view (drives s_ready, m_*, ram_* controls)
//                  master : environment view (producer, consumer and RAM)
//                Signals:
//                  s_valid/s_data/s_ready   producer push handshake
//                  m_valid/m_data/m_ready   consumer pop handshake
//                  ram_we/ram_wr_addr/ram_wr_din  RAM write port
//                  ram_re/ram_rd_addr/ram_rd_dout RAM read port (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_din;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_dout;

    modport slave (
        input  s_valid, s_data, m_ready, ram_rd_dout,
        output s_ready, m_valid, m_data,
               ram_we, ram_wr_addr, ram_wr_din, ram_re, ram_rd_addr
    );

    modport master (
        output s_valid, s_data, m_ready, ram_rd_dout,
        input  s_ready, m_valid, m_data,
               ram_we, ram_wr_addr, ram_wr_din, ram_re, ram_rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : Pointer/handshake controller that turns an external dual-port
//                RAM (1-cycle registered read, output held while re=0) into a
//                synchronous FIFO. A one-entry output slot is formed by the RAM
//                read register itself: m_data is ram_rd_dout directly.
//  Ports       :
//                clk      rising-edge clock
//                rst_n    asynchronous active-low reset
//                flush    synchronous clear of all FIFO contents
//                bus      ram_fifo_ctrl_if.slave (push, pop and RAM buses)
//                level    entries held in RAM plus output slot, 0..DEPTH+1
//                max_level, overflow_seen  statistics (FIFO_CTRL_STATS_EN only)
//  Options     : define FIFO_CTRL_STATS_EN to add the max_level high-watermark
//                and the sticky overflow_seen flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  flush,
    ram_fifo_ctrl_if.slave             bus,
    output logic [ADDR_WIDTH+1:0]      level
`ifdef FIFO_CTRL_STATS_EN
    ,
    output logic [ADDR_WIDTH+1:0]      max_level,
    output logic                       overflow_seen
`endif
);

    // ------------------------------------------------------------------
    // Elaboration guard: the pointer arithmetic assumes a power-of-two RAM.
    // ------------------------------------------------------------------
    generate
        if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_mismatch
            $error("ram_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
        end
    endgenerate

    // Output slot states
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   w_ram_cnt;
    logic                  w_ram_empty;
    logic                  w_ram_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_m_valid;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;

    // ------------------------------------------------------------------
    // Pointer status. The extra MSB distinguishes full from empty when
    // the address bits coincide.
    // ------------------------------------------------------------------
    assign w_ram_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ram_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                         (r_wr_ptr[ADDR_WIDTH]     != r_rd_ptr[ADDR_WIDTH]);

    // Readiness comes from registered pointers only, so a pop in the same
    // cycle never frees a full RAM for a push.
    assign w_push = bus.s_valid & ~w_ram_full & ~flush;
    // Prefetch whenever the slot is empty or is being emptied this cycle.
    assign w_pop  = ~w_ram_empty & (~w_m_valid | bus.m_ready) & ~flush;

    assign bus.s_ready     = ~w_ram_full;
    assign bus.ram_we      = w_push;
    assign bus.ram_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_wr_din  = bus.s_data;
    assign bus.ram_re      = w_pop;
    assign bus.ram_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];
    // The RAM read register holds its value while re=0, which keeps m_data
    // stable during a consumer stall.
    assign bus.m_data      = bus.ram_rd_dout;
    assign bus.m_valid     = w_m_valid;

    assign level = {1'b0, w_ram_cnt} + {{(ADDR_WIDTH+1){1'b0}}, w_m_valid};

    // ------------------------------------------------------------------
    // Pointers (wrap naturally at 2*DEPTH)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output slot FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = SLOT_EMPTY;
        end else if (w_pop) begin
            w_state_nxt = SLOT_FULL;
        end else if (bus.m_ready) begin
            w_state_nxt = SLOT_EMPTY;
        end
    end

    // Output slot FSM: outputs
    always_comb begin
        w_m_valid = 1'b0;
        if (r_state == SLOT_FULL) begin
            w_m_valid = 1'b1;
        end
    end

`ifdef FIFO_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: level high-watermark and sticky overflow attempt flag
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH+1:0] r_max_level;
    logic                  r_overflow_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_level     <= '0;
            r_overflow_seen <= 1'b0;
        end else if (flush) begin
            r_max_level     <= '0;
            r_overflow_seen <= 1'b0;
        end else begin
            if (level > r_max_level) begin
                r_max_level <= level;
            end
            if (bus.s_valid && w_ram_full) begin
                r_overflow_seen <= 1'b1;
            end
        end
    end

    assign max_level     = r_max_level;
    assign overflow_seen = r_overflow_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl. Contains a model of the
//                dual-port RAM and a queue-based reference of the FIFO
//                contents; all DUT outputs are compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [AW+1:0] level;
`ifdef FIFO_CTRL_STATS_EN
    logic [AW+1:0] max_level;
    logic          overflow_seen;
`endif

    int checks = 0;
    int errors = 0;

    ram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave),
        .level (level)
`ifdef FIFO_CTRL_STATS_EN
        ,
        .max_level     (max_level),
        .overflow_seen (overflow_seen)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read, output held when re=0, cleared by reset
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_wr_din;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ram_rd_dout <= '0;
        else if (bus.ram_re) bus.ram_rd_dout <= mem[bus.ram_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of words in RAM plus the output slot
    // ------------------------------------------------------------------
    logic [DW-1:0] q[$];
    logic          slot_v = 1'b0;
    logic [DW-1:0] slot_d = '0;
    int            wcnt = 0;
    int            rcnt = 0;

    always @(posedge clk or negedge rst_n) begin
        bit acc, pop;
        if (!rst_n || flush) begin
            q.delete();
            slot_v = 1'b0;
            wcnt = 0;
            rcnt = 0;
        end else begin
            acc = bus.s_valid && (q.size() < DEPTH);
            pop = (q.size() > 0) && (!slot_v || bus.m_ready);
            if (pop) begin
                slot_d = q.pop_front();
                slot_v = 1'b1;
                rcnt++;
            end else if (bus.m_ready) begin
                slot_v = 1'b0;
            end
            if (acc) begin
                q.push_back(bus.s_data);
                wcnt++;
            end
        end
    end

    // Compare process: outputs are stable at the falling edge
    always @(negedge clk) begin
        bit e_rdy, e_we, e_re;
        e_rdy = (q.size() < DEPTH);
        e_we  = bus.s_valid && e_rdy && !flush;
        e_re  = (q.size() > 0) && (!slot_v || bus.m_ready) && !flush;
        chk("s_ready", 32'(bus.s_ready), 32'(e_rdy));
        chk("m_valid", 32'(bus.m_valid), 32'(slot_v));
        if (slot_v) chk("m_data", 32'(bus.m_data), 32'(slot_d));
        chk("level", 32'(level), q.size() + 32'(slot_v));
        chk("ram_we", 32'(bus.ram_we), 32'(e_we));
        if (e_we) begin
            chk("wr_addr", 32'(bus.ram_wr_addr), wcnt % DEPTH);
            chk("wr_din", 32'(bus.ram_wr_din), 32'(bus.s_data));
        end
        chk("ram_re", 32'(bus.ram_re), 32'(e_re));
        if (e_re) chk("rd_addr", 32'(bus.ram_rd_addr), rcnt % DEPTH);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(base + i);
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 1);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_ram_re", 32'(bus.ram_re), 0);
        rst_n = 1'b1;
        step();

        // Single push, consumer stalled
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        #1;
        chk("p1_ram_we", 32'(bus.ram_we), 1);
        step();
        bus.s_valid = 1'b0;
        step();
        chk("p1_m_valid", 32'(bus.m_valid), 1);
        chk("p1_m_data", 32'(bus.m_data), 32'hA5);
        chk("p1_level", 32'(level), 1);
        bus.m_ready = 1'b1;
        repeat (3) step();

        // Fill to DEPTH+1, then one stalled push, then drain
        bus.m_ready = 1'b0;
        push_n(17, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        #1;
        chk("full_level", 32'(level), 17);
        chk("full_s_ready", 32'(bus.s_ready), 0);
        step();
        bus.s_valid = 1'b0;
        chk("full_m_data0", 32'(bus.m_data), 32'h00);
        bus.m_ready = 1'b1;
        repeat (20) step();
        chk("drained_level", 32'(level), 0);

        // Continuous push and pop
        for (int i = 0; i < 40; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(8'h40 + i);
            step();
            chk("stream_level_le2", 32'(level <= 2), 1);
        end
        bus.s_valid = 1'b0;
        repeat (4) step();

        // Toggling consumer during drain
        bus.m_ready = 1'b0;
        push_n(8, 8'h80);
        for (int i = 0; i < 24; i++) begin
            bus.m_ready = (i % 2 == 0);
            step();
        end
        bus.m_ready = 1'b1;
        repeat (4) step();

        // Flush at level 9 with a push in the flush cycle
        bus.m_ready = 1'b0;
        push_n(9, 8'hC0);
        chk("pre_flush_level", 32'(level), 9);
        flush = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        step();
        flush = 1'b0;
        bus.s_valid = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_m_valid", 32'(bus.m_valid), 0);
        chk("flush_s_ready", 32'(bus.s_ready), 1);
        repeat (3) step();
        chk("flush_not_stored", 32'(bus.m_valid), 0);

        // Asynchronous reset mid-stream
        bus.m_ready = 1'b0;
        push_n(5, 8'hD0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(bus.m_valid), 0);
        chk("arst_level", 32'(level), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();

`ifdef FIFO_CTRL_STATS_EN
        push_n(18, 8'h20);
        step();
        chk("stats_overflow", 32'(overflow_seen), 1);
        chk("stats_max_level", 32'(max_level), 17);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stats_flush_overflow", 32'(overflow_seen), 0);
`endif

        // Randomized traffic with occasional flush
        for (int i = 0; i < 500; i++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = DW'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0) ? (i % 128 < 64) : 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 59) == 0);
            step();
        end
        flush = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (25) step();
        chk("final_level", 32'(level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
